dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned WORD_BYTES = 8;

   // True when the byte address is word aligned and below the byte limit.
   function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] limit);
      return (addr[2:0] == 3'b000) && (addr < limit);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 64-bit word store: synchronous write, registered read, no reset.
module dmem_array #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata
);

   logic [63:0] mem [DEPTH];
   logic [63:0] rdata_q;

   // Write and read share the single port; read data holds until the next read.
   always_ff @(posedge CLK) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data-memory target with programmable wait states.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request; accepts on req_valid
// WAIT  | request latched, wait-state counter running down to 1
// RESP  | access done; response held until resp_ready
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned ADDR_W      = 64
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [63:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'(WORD_BYTES);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [63:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              rd_en_q, rd_en_d;

   logic              access;
   logic              acc_write;
   logic [ADDR_W-1:0] acc_addr;
   logic [63:0]       acc_wdata;
   logic              acc_ok;
   logic              ram_we;
   logic              ram_re;
   logic [63:0]       ram_rdata;

   // With zero wait states the access lands on the accept edge, so the
   // live request is used; otherwise the latched copy.
   always_comb begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      if (state_q == IDLE) begin
         acc_write = req_write;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
      end
      acc_ok = addr_ok(64'(acc_addr), LIMIT);
   end

   // Next-state logic, request latching and response status.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rd_en_d = rd_en_q;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
                  access  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = RESP;
               access  = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
               err_d   = 1'b0;
               rd_en_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (access) begin
         err_d   = ~acc_ok;
         rd_en_d = acc_ok & ~acc_write;
      end
   end

   // Reset wins over the access edge so a store still in WAIT never lands.
   assign ram_we = access & acc_write & acc_ok & ~reset;
   assign ram_re = access & ~acc_write & acc_ok & ~reset;

   // State and request registers.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 64'd0;
         err_q   <= 1'b0;
         rd_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rd_en_q <= rd_en_d;
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .CLK   (CLK),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (acc_addr[AW+2:3]),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   // The RAM read register holds stale data; only a good load exposes it.
   assign resp_rdata = rd_en_q ? ram_rdata : 64'd0;
   assign resp_err   = err_q;
   assign resp_valid = (state_q == RESP);
   assign req_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: vector table on a 2-wait-state build, hand sequences for
// reset corners and a zero-wait-state build.
module tb_dmem_responder;

   localparam int unsigned WA = 2;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;

   logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
   logic [63:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err, busy;
   logic [63:0] resp_rdata;

   logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_resp_ready = 1'b0;
   logic [63:0] b_req_addr = '0, b_req_wdata = '0;
   logic        b_req_ready, b_resp_valid, b_resp_err, b_busy;
   logic [63:0] b_resp_rdata;

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   dmem_responder #(.DEPTH(256), .WAIT_CYCLES(WA), .ADDR_W(64)) u_dut (
      .CLK(CLK), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
   );

   dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .ADDR_W(64)) u_dut0 (
      .CLK(CLK), .reset(reset),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
   );

   typedef struct {
      string       tag;
      logic        w;
      logic [63:0] a;
      logic [63:0] d;
      int          hold;
      logic        err;
      logic [63:0] rd;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string tag, input logic w, input logic [63:0] a,
                          input logic [63:0] d, input int hold, input logic err,
                          input logic [63:0] rd);
      vec_t v;
      v.tag = tag; v.w = w; v.a = a; v.d = d; v.hold = hold; v.err = err; v.rd = rd;
      vecs.push_back(v);
   endtask

   task automatic run_txn(input vec_t v);
      int k;
      @(negedge CLK);
      chk({v.tag, " req_ready idle"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_write = v.w; req_addr = v.a; req_wdata = v.d;
      @(posedge CLK);
      @(negedge CLK);
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      k = 0;
      while (!resp_valid && k < 20) begin
         @(negedge CLK);
         k++;
      end
      chk({v.tag, " latency"}, 64'(k + 1), 64'(WA + 1));
      chk({v.tag, " resp_valid"}, 64'(resp_valid), 64'd1);
      chk({v.tag, " resp_err"}, 64'(resp_err), 64'(v.err));
      chk({v.tag, " resp_rdata"}, resp_rdata, v.rd);
      chk({v.tag, " busy"}, 64'(busy), 64'd1);
      for (int i = 0; i < v.hold; i++) begin
         @(negedge CLK);
         chk({v.tag, " hold valid"}, 64'(resp_valid), 64'd1);
         chk({v.tag, " hold rdata"}, resp_rdata, v.rd);
         chk({v.tag, " hold req_ready"}, 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      @(negedge CLK);
      resp_ready = 1'b0;
      chk({v.tag, " post valid"}, 64'(resp_valid), 64'd0);
      chk({v.tag, " post rdata"}, resp_rdata, 64'd0);
      chk({v.tag, " post err"}, 64'(resp_err), 64'd0);
      chk({v.tag, " post req_ready"}, 64'(req_ready), 64'd1);
      chk({v.tag, " post busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   k, hs;
      logic prev_valid;

      add_vec("st18",    1'b1, 64'h18,  64'hDEADBEEF_CAFEF00D, 0, 1'b0, 64'd0);
      add_vec("ld18bp",  1'b0, 64'h18,  64'd0,                 5, 1'b0, 64'hDEADBEEF_CAFEF00D);
      add_vec("st00",    1'b1, 64'h0,   64'h01234567_89ABCDEF, 0, 1'b0, 64'd0);
      add_vec("ld1c",    1'b0, 64'h1C,  64'd0,                 0, 1'b1, 64'd0);
      add_vec("st800",   1'b1, 64'h800, 64'hFFFF_0000_FFFF,    0, 1'b1, 64'd0);
      add_vec("st03",    1'b1, 64'h3,   64'h5555,              0, 1'b1, 64'd0);
      add_vec("ld00",    1'b0, 64'h0,   64'd0,                 0, 1'b0, 64'h01234567_89ABCDEF);
      add_vec("st7f8",   1'b1, 64'h7F8, 64'hA5A5A5A5_5A5A5A5A, 0, 1'b0, 64'd0);
      add_vec("ld7f8",   1'b0, 64'h7F8, 64'd0,                 2, 1'b0, 64'hA5A5A5A5_5A5A5A5A);
      add_vec("ld808",   1'b0, 64'h808, 64'd0,                 0, 1'b1, 64'd0);
      add_vec("st20",    1'b1, 64'h20,  64'h2222,              0, 1'b0, 64'd0);
      add_vec("ld18b",   1'b0, 64'h18,  64'd0,                 0, 1'b0, 64'hDEADBEEF_CAFEF00D);

      // Reset for two cycles, then idle outputs.
      reset = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      reset = 1'b0;
      chk("rst req_ready", 64'(req_ready), 64'd1);
      chk("rst resp_valid", 64'(resp_valid), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst resp_rdata", resp_rdata, 64'd0);
      chk("rst resp_err", 64'(resp_err), 64'd0);
      chk("rst0 req_ready", 64'(b_req_ready), 64'd1);
      chk("rst0 resp_valid", 64'(b_resp_valid), 64'd0);

      foreach (vecs[i]) run_txn(vecs[i]);

      // Reset on the edge that would have performed a WAIT store: dropped.
      @(negedge CLK);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'h1111;
      @(posedge CLK);
      @(negedge CLK);
      req_valid = 1'b0; req_write = 1'b0;
      chk("midwait busy", 64'(busy), 64'd1);
      @(negedge CLK);
      chk("midwait still waiting", 64'(resp_valid), 64'd0);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      chk("midwait rst valid", 64'(resp_valid), 64'd0);
      chk("midwait rst req_ready", 64'(req_ready), 64'd1);
      chk("midwait rst busy", 64'(busy), 64'd0);
      v.tag = "ld20 after drop"; v.w = 1'b0; v.a = 64'h20; v.d = '0; v.hold = 0;
      v.err = 1'b0; v.rd = 64'h2222;
      run_txn(v);

      // Reset while in RESP after a store: the write has already happened.
      @(negedge CLK);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h28; req_wdata = 64'h3333;
      @(posedge CLK);
      @(negedge CLK);
      req_valid = 1'b0; req_write = 1'b0;
      k = 0;
      while (!resp_valid && k < 20) begin
         @(negedge CLK);
         k++;
      end
      chk("inresp valid", 64'(resp_valid), 64'd1);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      chk("inresp rst valid", 64'(resp_valid), 64'd0);
      chk("inresp rst busy", 64'(busy), 64'd0);
      v.tag = "ld28 kept"; v.w = 1'b0; v.a = 64'h28; v.d = '0; v.hold = 0;
      v.err = 1'b0; v.rd = 64'h3333;
      run_txn(v);

      // Zero-wait build: accept edge N gives resp_valid by edge N+1.
      @(negedge CLK);
      b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 64'h40; b_req_wdata = 64'hFEED_BEEF;
      @(posedge CLK);
      @(negedge CLK);
      b_req_valid = 1'b0; b_req_write = 1'b0;
      chk("w0 latency valid", 64'(b_resp_valid), 64'd1);
      chk("w0 store err", 64'(b_resp_err), 64'd0);
      chk("w0 req_ready in resp", 64'(b_req_ready), 64'd0);
      b_resp_ready = 1'b1;
      @(negedge CLK);
      b_resp_ready = 1'b0;
      chk("w0 post valid", 64'(b_resp_valid), 64'd0);
      chk("w0 post req_ready", 64'(b_req_ready), 64'd1);

      // Back-to-back loads with req_valid held high.
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 64'h40;
      b_resp_ready = 1'b1;
      hs = 0;
      prev_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         if (prev_valid) begin
            chk("b2b idle after hs", 64'(b_req_ready), 64'd1);
            chk("b2b no resp after hs", 64'(b_resp_valid), 64'd0);
         end
         if (b_resp_valid) begin
            hs++;
            chk("b2b rdata", b_resp_rdata, 64'hFEED_BEEF);
            chk("b2b no accept in hs", 64'(b_req_ready), 64'd0);
         end
         prev_valid = b_resp_valid;
      end
      b_req_valid = 1'b0;
      k = 0;
      while (b_busy && k < 10) begin
         @(negedge CLK);
         k++;
      end
      b_resp_ready = 1'b0;
      chk("b2b completions >= 3", 64'(hs >= 3), 64'd1);
      chk("b2b drained", 64'(b_busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
